fft_sink_feeder: RTL and testbench

Frame-building source for the FFT sink interface: captures a continuous acquisition sample stream after a sweep trigger, buffers it in a small show-ahead FIFO, and presents exactly `transform_length` samples per frame on the `master_sink_*` handshake of the FFT core. It is the transmitting end of the sink protocol that the FFT top consumes, and runs in the FFT's clock domain.

---
 rtl/fft_sink_feeder.sv | 146 ++++++++++++++
 tb/tb_fft_sink_feeder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sink_feeder.sv
// Frame source for the FFT sink handshake: captures transform_length samples after a
// trigger into a show-ahead FIFO and presents them on master_sink_* with dav/ena flow control.
module fft_sink_feeder #(
   parameter int data_width            = 16,
   parameter int transform_length      = 32768,
   parameter int log2_transform_length = 15,
   parameter int fifo_add_width        = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  inv_req,
   input  logic                  sample_valid,
   input  logic [data_width-1:0] sample_real_in,
   input  logic [data_width-1:0] sample_imag_in,
   input  logic                  master_sink_ena,
   output logic                  master_sink_dav,
   output logic                  master_sink_sop,
   output logic                  inv_i,
   output logic [data_width-1:0] data_real_out,
   output logic [data_width-1:0] data_imag_out,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overflow
);

   localparam int CNT_W = log2_transform_length + 1;
   localparam int DEPTH = 1 << fifo_add_width;
   localparam logic [CNT_W-1:0]          LEN      = CNT_W'(transform_length);
   localparam logic [CNT_W-1:0]          LAST     = CNT_W'(transform_length - 1);
   localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
   localparam logic [fifo_add_width-1:0] PTR_ONE  = fifo_add_width'(1);
   localparam logic [fifo_add_width:0]   OCC_ONE  = (fifo_add_width + 1)'(1);
   localparam logic [fifo_add_width:0]   OCC_FULL = (fifo_add_width + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t                      state_q, state_d;
   logic [2*data_width-1:0]     mem_q [DEPTH];
   logic [fifo_add_width-1:0]   wr_ptr_q, wr_ptr_d;
   logic [fifo_add_width-1:0]   rd_ptr_q, rd_ptr_d;
   logic [fifo_add_width:0]     occ_q, occ_d;
   logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]            tx_cnt_q, tx_cnt_d;
   logic                        inv_q, inv_d;
   logic                        done_q, done_d;
   logic                        ovf_q, ovf_d;

   logic                        capture, dav, pop, full, wr, drop;
   logic [2*data_width-1:0]     head;

   // A sample is eligible in FILL, or in IDLE only together with an accepted trigger.
   assign capture = (state_q == FILL) || ((state_q == IDLE) && frame_start);
   assign dav     = (occ_q != '0) && (state_q != IDLE);
   assign pop     = dav && master_sink_ena;
   assign full    = (occ_q == OCC_FULL);
   assign wr      = sample_valid && capture && (!full || pop);
   assign drop    = sample_valid && capture && full && !pop;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      wr_cnt_d = wr_cnt_q;
      tx_cnt_d = tx_cnt_q;
      inv_d    = inv_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q | drop;

      if (wr)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
      case ({wr, pop})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               inv_d    = inv_req;
               tx_cnt_d = '0;
               wr_cnt_d = wr ? CNT_ONE : '0;
               state_d  = (wr && (CNT_ONE == LEN)) ? DRAIN : FILL;
            end
         end
         FILL: begin
            if (wr) begin
               wr_cnt_d = wr_cnt_q + CNT_ONE;
               if (wr_cnt_d == LEN) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && (tx_cnt_q == LAST)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         wr_cnt_q <= '0;
         tx_cnt_q <= '0;
         inv_q    <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         wr_cnt_q <= wr_cnt_d;
         tx_cnt_q <= tx_cnt_d;
         inv_q    <= inv_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
      end
   end

   // Sample storage carries no reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= {sample_real_in, sample_imag_in};
   end

   assign master_sink_dav = dav;
   assign master_sink_sop = dav && (tx_cnt_q == '0);
   assign inv_i           = inv_q;
   assign data_real_out   = dav ? head[2*data_width-1:data_width] : '0;
   assign data_imag_out   = dav ? head[data_width-1:0] : '0;
   assign busy            = (state_q != IDLE);
   assign frame_done      = done_q;
   assign overflow        = ovf_q;

endmodule

// File: tb/tb_fft_sink_feeder.sv
// Scoreboard bench for fft_sink_feeder with an 8-sample frame and a 4-entry FIFO.
module tb_fft_sink_feeder;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset, frame_start, inv_req, sample_valid, master_sink_ena;
   logic [W-1:0]  sample_real_in, sample_imag_in;
   logic          master_sink_dav, master_sink_sop, inv_i, busy, frame_done, overflow;
   logic [W-1:0]  data_real_out, data_imag_out;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [31:0]   exp_q[$];
   int            xfer_cnt = 0;
   int            sop_cnt  = 0;
   bit            first_flag = 1'b1;
   bit            hold_pend  = 1'b0;
   logic [31:0]   hold_val;
   logic [31:0]   exp_v;

   fft_sink_feeder #(
      .data_width(W), .transform_length(8), .log2_transform_length(3), .fifo_add_width(2)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .inv_req(inv_req),
      .sample_valid(sample_valid), .sample_real_in(sample_real_in),
      .sample_imag_in(sample_imag_in), .master_sink_ena(master_sink_ena),
      .master_sink_dav(master_sink_dav), .master_sink_sop(master_sink_sop),
      .inv_i(inv_i), .data_real_out(data_real_out), .data_imag_out(data_imag_out),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pack(input int v);
      return {16'(v), 16'(v) ^ 16'hA5A5};
   endfunction

   // Scoreboard monitor: inputs settle after the rising edge, so the falling edge sees the
   // exact dav/ena pair that decides the upcoming transfer.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         first_flag = 1'b1;
         hold_pend  = 1'b0;
      end else begin
         if (hold_pend) begin
            n_checks++;
            if (master_sink_dav !== 1'b1 || {data_real_out, data_imag_out} !== hold_val) begin
               n_fail++;
               $display("FAIL hold: dav=%b data=%h required dav=1 data=%h",
                        master_sink_dav, {data_real_out, data_imag_out}, hold_val);
            end
         end
         hold_pend = 1'b0;
         if (master_sink_dav === 1'b0) begin
            n_checks++;
            if (master_sink_sop !== 1'b0) begin
               n_fail++;
               $display("FAIL sop_without_dav: sop=%b required 0", master_sink_sop);
            end
         end
         if (master_sink_dav === 1'b1 && master_sink_ena === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_xfer: data=%h required no transfer",
                        {data_real_out, data_imag_out});
            end else begin
               exp_v = exp_q.pop_front();
               if ({data_real_out, data_imag_out} !== exp_v) begin
                  n_fail++;
                  $display("FAIL xfer_data: got %h required %h",
                           {data_real_out, data_imag_out}, exp_v);
               end
            end
            n_checks++;
            if (master_sink_sop !== first_flag) begin
               n_fail++;
               $display("FAIL xfer_sop: got %b required %b", master_sink_sop, first_flag);
            end
            if (master_sink_sop === 1'b1) sop_cnt++;
            xfer_cnt++;
            first_flag = 1'b0;
         end else if (master_sink_dav === 1'b1) begin
            hold_pend = 1'b1;
            hold_val  = {data_real_out, data_imag_out};
         end
         if (frame_done === 1'b1) first_flag = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fs, input logic v, input int d);
      frame_start    = fs;
      sample_valid   = v;
      sample_real_in = 16'(d);
      sample_imag_in = 16'(d) ^ 16'hA5A5;
   endtask

   task automatic run_until_done(input int bound, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < bound; c++) begin
         tick();
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; inv_req = 1'b0; master_sink_ena = 1'b0;
      drive(1'b0, 1'b0, 0);
      tick(); tick();
      n_checks++;
      if ({master_sink_dav, master_sink_sop, inv_i, busy, frame_done, overflow,
           data_real_out, data_imag_out} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: dav=%b sop=%b inv=%b busy=%b done=%b ovf=%b re=%h im=%h required all 0",
                  master_sink_dav, master_sink_sop, inv_i, busy, frame_done, overflow,
                  data_real_out, data_imag_out);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      int x0 = xfer_cnt, s0 = sop_cnt;
      master_sink_ena = 1'b1;
      drive(1'b1, 1'b0, 0);
      tick();
      n_checks++;
      if (busy !== 1'b1 || master_sink_dav !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_armed: busy=%b dav=%b required busy=1 dav=0", busy, master_sink_dav);
      end
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b1, i);
         exp_q.push_back(pack(i));
         tick();
         n_checks++;
         if (master_sink_dav !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_dav_latency: after sample %0d dav=%b required 1", i, master_sink_dav);
         end
      end
      drive(1'b0, 1'b0, 0);
      run_until_done(40, ok);
      n_checks++;
      if (!ok || busy !== 1'b0 || master_sink_dav !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: done_seen=%b busy=%b dav=%b ovf=%b required 1 0 0 0",
                  ok, busy, master_sink_dav, overflow);
      end
      tick();
      n_checks++;
      if (frame_done !== 1'b0 || xfer_cnt - x0 != 8 || sop_cnt - s0 != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL basic_counts: done=%b xfers=%0d sops=%0d left=%0d required 0 8 1 0",
                  frame_done, xfer_cnt - x0, sop_cnt - s0, exp_q.size());
      end
   endtask

   task automatic test_ena_toggle();
      int x0 = xfer_cnt, s0 = sop_cnt;
      int sent = 0;
      bit ok = 1'b0;
      master_sink_ena = 1'b0;
      drive(1'b1, 1'b0, 0);
      tick();
      for (int c = 0; c < 80; c++) begin
         master_sink_ena = (c % 2 == 0);
         if (sent < 8 && c % 2 == 0) begin
            sent++;
            drive(1'b0, 1'b1, 20 + sent);
            exp_q.push_back(pack(20 + sent));
         end else begin
            drive(1'b0, 1'b0, 0);
         end
         tick();
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || xfer_cnt - x0 != 8 || sop_cnt - s0 != 1 || overflow !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL toggle_frame: done_seen=%b xfers=%0d sops=%0d ovf=%b left=%0d required 1 8 1 0 0",
                  ok, xfer_cnt - x0, sop_cnt - s0, overflow, exp_q.size());
      end
      master_sink_ena = 1'b1;
      tick();
   endtask

   task automatic test_overflow();
      bit ok;
      int x0 = xfer_cnt;
      master_sink_ena = 1'b0;
      drive(1'b1, 1'b0, 0);
      tick();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b0, 1'b1, i);
         if (i <= 4) exp_q.push_back(pack(i));
         tick();
      end
      n_checks++;
      if (overflow !== 1'b1 || master_sink_dav !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: ovf=%b dav=%b required 1 1", overflow, master_sink_dav);
      end
      master_sink_ena = 1'b1;
      for (int i = 7; i <= 10; i++) begin
         drive(1'b0, 1'b1, i);
         exp_q.push_back(pack(i));
         tick();
      end
      drive(1'b0, 1'b0, 0);
      run_until_done(40, ok);
      n_checks++;
      if (!ok || overflow !== 1'b1 || xfer_cnt - x0 != 8 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL ovf_frame: done_seen=%b ovf=%b xfers=%0d left=%0d required 1 1 8 0",
                  ok, overflow, xfer_cnt - x0, exp_q.size());
      end
      tick(); tick();
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: ovf=%b required 1", overflow);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: ovf=%b required 0", overflow);
      end
      tick();
   endtask

   task automatic test_inv();
      bit ok;
      int done_seen = 0;
      master_sink_ena = 1'b1;
      inv_req = 1'b1;
      drive(1'b1, 1'b0, 0);
      tick();
      for (int i = 1; i <= 8; i++) begin
         inv_req = 1'(i % 2);
         drive(i == 4, 1'b1, 40 + i);
         exp_q.push_back(pack(40 + i));
         tick();
         n_checks++;
         if (inv_i !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_hold: sample %0d inv=%b busy=%b required 1 1", i, inv_i, busy);
         end
      end
      drive(1'b0, 1'b0, 0);
      inv_req = 1'b0;
      run_until_done(40, ok);
      if (ok) done_seen++;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (frame_done === 1'b1) done_seen++;
      end
      n_checks++;
      if (done_seen != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL inv_single_frame: done_pulses=%0d busy=%b left=%0d required 1 0 0",
                  done_seen, busy, exp_q.size());
      end
      drive(1'b1, 1'b0, 0);
      tick();
      n_checks++;
      if (inv_i !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL inv_next_frame: inv=%b busy=%b required 0 1", inv_i, busy);
      end
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b1, 50 + i);
         exp_q.push_back(pack(50 + i));
         tick();
      end
      drive(1'b0, 1'b0, 0);
      run_until_done(40, ok);
      n_checks++;
      if (!ok || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL inv_second_done: done_seen=%b left=%0d required 1 0", ok, exp_q.size());
      end
      tick();
   endtask

   task automatic test_idle_samples();
      bit ok;
      int x0 = xfer_cnt, s0 = sop_cnt;
      master_sink_ena = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 99);
         tick();
      end
      n_checks++;
      if (busy !== 1'b0 || master_sink_dav !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignore: busy=%b dav=%b ovf=%b required 0 0 0", busy, master_sink_dav, overflow);
      end
      for (int i = 1; i <= 8; i++) begin
         drive(i == 1, 1'b1, i);
         exp_q.push_back(pack(i));
         tick();
      end
      drive(1'b0, 1'b0, 0);
      run_until_done(40, ok);
      n_checks++;
      if (!ok || xfer_cnt - x0 != 8 || sop_cnt - s0 != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL idle_frame: done_seen=%b xfers=%0d sops=%0d left=%0d required 1 8 1 0",
                  ok, xfer_cnt - x0, sop_cnt - s0, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reset_midframe();
      bit ok;
      int x0;
      master_sink_ena = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(i == 1, 1'b1, 70 + i);
         tick();
      end
      drive(1'b0, 1'b0, 0);
      n_checks++;
      if (master_sink_dav !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_prereset: dav=%b busy=%b required 1 1", master_sink_dav, busy);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({master_sink_dav, master_sink_sop, inv_i, busy, frame_done, overflow,
           data_real_out, data_imag_out} !== 38'd0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: dav=%b sop=%b inv=%b busy=%b done=%b ovf=%b re=%h im=%h required all 0",
                  master_sink_dav, master_sink_sop, inv_i, busy, frame_done, overflow,
                  data_real_out, data_imag_out);
      end
      reset = 1'b1;
      master_sink_ena = 1'b1;
      tick();
      n_checks++;
      if (master_sink_dav !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_fifo_empty: dav=%b required 0", master_sink_dav);
      end
      x0 = xfer_cnt;
      for (int i = 1; i <= 8; i++) begin
         drive(i == 1, 1'b1, 80 + i);
         exp_q.push_back(pack(80 + i));
         tick();
      end
      drive(1'b0, 1'b0, 0);
      run_until_done(40, ok);
      n_checks++;
      if (!ok || xfer_cnt - x0 != 8 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_fresh_frame: done_seen=%b xfers=%0d left=%0d required 1 8 0",
                  ok, xfer_cnt - x0, exp_q.size());
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ena_toggle();
      test_overflow();
      test_inv();
      test_idle_samples();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
